pipe_share_arb: RTL
===================

Name: pipe_share_arb

Overview:
Round-robin arbiter and sequencer that shares one 2-bit registered compare pipeline among N requesters. The shared pipeline is din[1:0] to dout with a fixed LAT-cycle latency, no stall and no reset. The block grants at most one requester per cycle and drives the pipeline input. It tracks each in-flight operation with a {valid,id} tag shift register and returns each result tagged with its requester id. A hold/drain controller quiesces the pipeline for reconfiguration or test.

Parameters:
N, 4, number of requesters (2..8)
LAT, 4, pipeline latency in sclk cycles from pipe_din to pipe_dout (1..8)
IDW, $clog2(N), derived localparam: width of requester id

Ports:
sclk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
req  in  N  request per requester, level, held until granted
req_data  in  2N  2-bit operand per requester, requester i at [2i+1:2i]
gnt  out  N  one-hot grant, combinational, transfer = req[i] & gnt[i]
pipe_din  out  2  operand to shared pipeline
pipe_dout  in  1  shared pipeline result, LAT cycles after pipe_din
res_valid  out  1  result valid this cycle
res_id  out  IDW  requester owning result
res_data  out  1  result bit (combinational pass of pipe_dout)
hold  in  1  request to stop issuing and drain
idle  out  1  pipeline drained and halted
inflight  out  $clog2(LAT+1)  number of valid tags in flight

Behaviour:
- Reset (async, rst=1): state=RUN, rr pointer=N-1 (requester 0 highest priority first), all tags invalid, inflight=0, res_valid=0, res_id=0, idle=0, gnt=0 while rst=1.
- Arbitration (state RUN only): search starts at ptr+1 mod N; the first i with req[i]=1 gets gnt[i]=1. gnt=0 if no request or state!=RUN. gnt is never asserted to a requester with req=0.
- On a transfer: ptr<=i; pipe_din=req_data[2i+1:2i]; tag stage0<={1,i}.
- No transfer: pipe_din=2'b00 (bubble); tag stage0<={0,0}.
- Tag pipe: LAT-stage shift register, advances every cycle unconditionally. res_valid/res_id = stage LAT-1 outputs. res_data=pipe_dout, meaningful only when res_valid=1. Grant at edge t gives res_valid in cycle t+LAT. Results have no backpressure, and throughput is 1 per cycle.
- inflight = count of valid tags. Updated as +1 on issue and -1 on retire; issue and retire in the same cycle leaves it unchanged. Never exceeds LAT.
- FSM:
  - RUN: if hold=1, go to DRAIN. Grants are suppressed in the same cycle hold is seen (combinational gating).
  - DRAIN: no grants. If hold=0, go to RUN. Else if inflight=0, go to HALT.
  - HALT: idle=1, no grants. If hold=0, go to RUN (idle=0 next cycle).
- idle=1 only in HALT.
- Reset mid-operation: tags cleared, so results already in the external pipeline are discarded (res_valid=0) even though pipe_dout may still toggle.
- Golden pipeline function: dout = 0 iff din==2'b00, else 1.

Test Plan:
1. Reset, then req=4'b0001, req_data[1:0]=2'b00 for one grant: gnt=0001 at t; res_valid=1, res_id=0, res_data=0 at t+4; inflight=1 during t+1..t+4.
2. req=4'b1111 held with distinct operands (01,10,11,00) for 8 cycles: grant order 0,1,2,3,0,1,2,3, one per cycle. Results appear back-to-back from t+4 with ids 0,1,2,3,… and data 1,1,1,0.
3. Fairness: req=4'b1010 continuous. Grants alternate 1,3,1,3. After ptr=3, raising req[0] gives requester 0 the next grant.
4. Drain: 4 grants issued, then hold=1. gnt=0 from that cycle; inflight counts 4 down to 0; idle=1 the cycle after inflight reaches 0. Deassert hold: RUN, and grants resume the next cycle.
5. hold pulses 1 cycle in DRAIN with inflight=3: returns to RUN, idle never asserts, and no result is lost.
6. Async rst asserted mid-stream with 3 tags in flight: res_valid=0 immediately and stays 0 for the next LAT cycles; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/pipe_share_arb_if.sv
// Requester, shared-pipeline and result signals of the pipe_share_arb block.
// The slave side is the arbiter; the master side is the requesters plus pipeline.
interface pipe_share_arb_if #(
    parameter int N   = 4,
    parameter int LAT = 4
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(LAT + 1);

    logic [N-1:0]     req;
    logic [2*N-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic [1:0]       pipe_din;
    logic             pipe_dout;
    logic             res_valid;
    logic [IDW-1:0]   res_id;
    logic             res_data;
    logic             hold;
    logic             idle;
    logic [CW-1:0]    inflight;

    modport master (
        output req, req_data, pipe_dout, hold,
        input  gnt, pipe_din, res_valid, res_id, res_data, idle, inflight
    );

    modport slave (
        input  req, req_data, pipe_dout, hold,
        output gnt, pipe_din, res_valid, res_id, res_data, idle, inflight
    );
endinterface

// File: rtl/pipe_share_arb.sv
// Round-robin arbiter sharing one fixed-latency 2-bit compare pipeline among N
// requesters, with {valid,id} tag tracking and a hold/drain/halt controller.
module pipe_share_arb #(
    parameter int N   = 4,
    parameter int LAT = 4
) (
    input  logic             sclk,
    input  logic             rst,
    pipe_share_arb_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_idle;
    logic [IDW-1:0]   r_ptr;
    logic [LAT-1:0]   r_tag_v;
    logic [IDW-1:0]   r_tag_id [LAT];
    logic [CW-1:0]    r_inflight;

    logic             w_en;
    logic             w_found;
    logic             w_xfer;
    logic             w_retire;
    logic [N-1:0]     w_gnt;
    logic [IDW-1:0]   w_gid;
    logic [IDW-1:0]   w_idx;
    logic [1:0]       w_din;

    // Gating is combinational so a hold or reset suppresses grants in the same cycle.
    assign w_en     = (r_state == ST_RUN) && !bus.hold && !rst;
    assign w_xfer   = |(bus.req & w_gnt);
    assign w_retire = r_tag_v[LAT-1];

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        w_gnt   = '0;
        w_gid   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_din   = 2'b00;
        for (int k = 1; k <= N; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % N);
            if (w_en && !w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_gid   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
        if (w_found) begin
            w_gnt[w_gid] = 1'b1;
            w_din        = bus.req_data[{w_gid, 1'b0} +: 2];
        end else begin
            w_din = 2'b00;
        end
    end

    // Run/drain/halt controller and round-robin pointer.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
            r_ptr   <= IDW'(N - 1);
        end else begin
            if (w_xfer) begin
                r_ptr <= w_gid;
            end else begin
                r_ptr <= r_ptr;
            end
            case (r_state)
                ST_RUN: begin
                    r_state <= bus.hold ? ST_DRAIN : ST_RUN;
                    r_idle  <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!bus.hold) begin
                        r_state <= ST_RUN;
                        r_idle  <= 1'b0;
                    end else if (r_inflight == '0) begin
                        r_state <= ST_HALT;
                        r_idle  <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                        r_idle  <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_state <= bus.hold ? ST_HALT : ST_RUN;
                    r_idle  <= bus.hold;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_idle  <= 1'b0;
                end
            endcase
        end
    end

    // Tag shift register mirrors the external pipeline; inflight counts its valid tags.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_tag_v    <= '0;
            r_inflight <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_xfer;
            r_tag_id[0] <= w_xfer ? w_gid : '0;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
            case ({w_xfer, w_retire})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.pipe_din  = w_din;
    assign bus.res_valid = r_tag_v[LAT-1];
    assign bus.res_id    = r_tag_id[LAT-1];
    assign bus.res_data  = bus.pipe_dout;
    assign bus.idle      = r_idle;
    assign bus.inflight  = r_inflight;
endmodule
